// File: rtl/pcie_scrambler_xn.sv
// ---------------------------------------------------------------------------
// pcie_scrambler_xn
//
// Purpose:
//   Multi-lane, multi-symbol-per-clock PCIe Gen1/Gen2 scrambler for the
//   8b/10b domain. Sits between the ordered-set/data mux and the 8b/10b
//   encoder on the transmit path. Each lane owns an independent 16-bit LFSR
//   (x^16 + x^5 + x^4 + x^3 + 1) that advances 8 bits per scrambled symbol.
//   Within a clock, SYMS symbols per lane are processed in time order
//   (symbol 0 first), each seeing the LFSR state left by the previous one.
//
// Symbol rules (highest priority first):
//   K + COM (BC) : pass through, LFSR reloads LFSR_SEED (even if disabled)
//   K + SKP (1C) : pass through, LFSR holds
//   lane disabled: pass through, LFSR holds
//   other K      : pass through, LFSR advances
//   D symbol     : out[i] = in[i] ^ lfsr[15-i], LFSR advances
//
// Ports:
//   clk_i              in   1              clock
//   rst_i              in   1              synchronous active-high reset
//   valid_i            in   1              input word valid
//   data_i             in   LANES*SYMS*8   lane L symbol j at [(L*SYMS+j)*8 +: 8]
//   datak_i            in   LANES*SYMS     K flag per symbol, same indexing
//   scramble_enable_i  in   LANES          per-lane scramble enable
//   valid_o            out  1              output word valid (1 clock latency)
//   data_o             out  LANES*SYMS*8   scrambled symbols (held when idle)
//   datak_o            out  LANES*SYMS     K flags aligned with data_o
//   lfsr_state_o       out  LANES*16       registered LFSR per lane (debug)
// ---------------------------------------------------------------------------
module pcie_scrambler_xn #(
    parameter int          LANES     = 4,
    parameter int          SYMS      = 2,
    parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [LANES*SYMS*8-1:0]  data_i,
    input  logic [LANES*SYMS-1:0]    datak_i,
    input  logic [LANES-1:0]         scramble_enable_i,
    output logic                     valid_o,
    output logic [LANES*SYMS*8-1:0]  data_o,
    output logic [LANES*SYMS-1:0]    datak_o,
    output logic [LANES*16-1:0]      lfsr_state_o
);

    localparam int          NSYM    = LANES * SYMS;
    localparam logic [7:0]  SYM_COM = 8'hBC;
    localparam logic [7:0]  SYM_SKP = 8'h1C;

    // Eight serial shifts of the Galois LFSR collapsed into one parallel step.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
        logic [15:0] n;
        n[0]  = s[8];
        n[1]  = s[9];
        n[2]  = s[10];
        n[3]  = s[8]  ^ s[11];
        n[4]  = s[8]  ^ s[9]  ^ s[12];
        n[5]  = s[8]  ^ s[9]  ^ s[10] ^ s[13];
        n[6]  = s[9]  ^ s[10] ^ s[11] ^ s[14];
        n[7]  = s[10] ^ s[11] ^ s[12] ^ s[15];
        n[8]  = s[0]  ^ s[11] ^ s[12] ^ s[13];
        n[9]  = s[1]  ^ s[12] ^ s[13] ^ s[14];
        n[10] = s[2]  ^ s[13] ^ s[14] ^ s[15];
        n[11] = s[3]  ^ s[14] ^ s[15];
        n[12] = s[4]  ^ s[15];
        n[13] = s[5];
        n[14] = s[6];
        n[15] = s[7];
        return n;
    endfunction

    // Data bit i is keyed by LFSR bit 15-i (MSB is the first serial key bit).
    function automatic logic [7:0] scramble_byte(input logic [7:0] d,
                                                 input logic [15:0] s);
        logic [7:0] o;
        for (int i = 0; i < 8; i++) begin
            o[i] = d[i] ^ s[15-i];
        end
        return o;
    endfunction

    logic                         r_valid;
    logic [NSYM*8-1:0]            r_data;
    logic [NSYM-1:0]              r_datak;
    logic [LANES-1:0][15:0]       r_lfsr;

    logic [NSYM*8-1:0]            w_data;
    logic [LANES-1:0][15:0]       w_lfsr_next;

    // Per-lane symbol chain: the state walks through the lane's symbols in
    // time order, so a COM at symbol j already reseeds symbol j+1.
    always_comb begin
        logic [15:0] w_state;
        logic [7:0]  w_sym;
        logic        w_k;
        int          idx;
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        w_data      = '0;
        w_lfsr_next = r_lfsr;
        w_state     = '0;
        w_sym       = '0;
        w_k         = 1'b0;
        idx         = 0;
        for (int l = 0; l < LANES; l++) begin
            w_state = r_lfsr[l];
            for (int j = 0; j < SYMS; j++) begin
                idx   = l * SYMS + j;
                w_sym = data_i[idx*8 +: 8];
                w_k   = datak_i[idx];
                if (w_k && (w_sym == SYM_COM)) begin
                    // COM resynchronises the receiver, so it reseeds even on
                    // a lane whose scrambling is turned off.
                    w_data[idx*8 +: 8] = w_sym;
                    w_state            = LFSR_SEED;
                end else if (w_k && (w_sym == SYM_SKP)) begin
                    // SKPs may be added/removed by retimers; they must not
                    // consume key stream.
                    w_data[idx*8 +: 8] = w_sym;
                end else if (!scramble_enable_i[l]) begin
                    w_data[idx*8 +: 8] = w_sym;
                end else if (w_k) begin
                    w_data[idx*8 +: 8] = w_sym;
                    w_state            = lfsr_advance(w_state);
                end else begin
                    w_data[idx*8 +: 8] = scramble_byte(w_sym, w_state);
                    w_state            = lfsr_advance(w_state);
                end
            end
            w_lfsr_next[l] = w_state;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_datak <= '0;
            r_lfsr  <= {LANES{LFSR_SEED}};
        end else begin
            r_valid <= valid_i;
            // Idle cycles freeze outputs and key stream so the sequence
            // resumes seamlessly on the next valid word.
            if (valid_i) begin
                r_data  <= w_data;
                r_datak <= datak_i;
                r_lfsr  <= w_lfsr_next;
            end
        end
    end

    assign valid_o      = r_valid;
    assign data_o       = r_data;
    assign datak_o      = r_datak;
    assign lfsr_state_o = r_lfsr;

endmodule

// File: tb/tb_pcie_scrambler_xn.sv
// ---------------------------------------------------------------------------
// tb_pcie_scrambler_xn
//
// Self-checking bench for pcie_scrambler_xn (LANES=4, SYMS=2). The reference
// model keeps one LFSR per lane and produces key bits one serial shift at a
// time from the polynomial x^16+x^5+x^4+x^3+1; expected outputs and LFSR
// states come from that model plus a few hand-derived constants.
// ---------------------------------------------------------------------------
module tb_pcie_scrambler_xn;

    localparam int          LANES = 4;
    localparam int          SYMS  = 2;
    localparam int          NSYM  = LANES * SYMS;
    localparam logic [15:0] SEED  = 16'hFFFF;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                valid_i;
    logic [NSYM*8-1:0]   data_i;
    logic [NSYM-1:0]     datak_i;
    logic [LANES-1:0]    scramble_enable_i;
    logic                valid_o;
    logic [NSYM*8-1:0]   data_o;
    logic [NSYM-1:0]     datak_o;
    logic [LANES*16-1:0] lfsr_state_o;

    pcie_scrambler_xn #(.LANES(LANES), .SYMS(SYMS), .LFSR_SEED(SEED)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .valid_i           (valid_i),
        .data_i            (data_i),
        .datak_i           (datak_i),
        .scramble_enable_i (scramble_enable_i),
        .valid_o           (valid_o),
        .data_o            (data_o),
        .datak_o           (datak_o),
        .lfsr_state_o      (lfsr_state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0]         m_lfsr [LANES];
    logic                exp_valid;
    logic [NSYM*8-1:0]   exp_data;
    logic [NSYM-1:0]     exp_datak;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One serial LFSR shift; returns the key bit that was at the MSB.
    function automatic logic [15:0] shift1(input logic [15:0] s, output logic key);
        key = s[15];
        return {s[14:0], 1'b0} ^ (key ? 16'h0039 : 16'h0000);
    endfunction

    function automatic logic [7:0] sym_out(input int lane, input int j);
        return data_o[(lane*SYMS+j)*8 +: 8];
    endfunction

    function automatic logic [15:0] lfsr_out(input int lane);
        return lfsr_state_o[lane*16 +: 16];
    endfunction

    function automatic logic [63:0] model_lfsr_flat();
        logic [63:0] f;
        f = '0;
        for (int l = 0; l < LANES; l++) f[l*16 +: 16] = m_lfsr[l];
        return f;
    endfunction

    task automatic model_word();
        logic [15:0] s;
        logic [7:0]  b, key;
        logic        k, kb;
        int          idx;
        for (int l = 0; l < LANES; l++) begin
            s = m_lfsr[l];
            for (int j = 0; j < SYMS; j++) begin
                idx = l * SYMS + j;
                b   = data_i[idx*8 +: 8];
                k   = datak_i[idx];
                if (k && b == 8'hBC) begin
                    exp_data[idx*8 +: 8] = b;
                    s = SEED;
                end else if ((k && b == 8'h1C) || !scramble_enable_i[l]) begin
                    exp_data[idx*8 +: 8] = b;
                end else begin
                    for (int i = 0; i < 8; i++) begin
                        s = shift1(s, kb);
                        key[i] = kb;
                    end
                    exp_data[idx*8 +: 8] = k ? b : (b ^ key);
                end
            end
            m_lfsr[l] = s;
        end
        exp_datak = datak_i;
    endtask

    // Apply current data_i/datak_i/enable with the given valid/reset for one
    // clock, update the model and compare all outputs after the edge.
    task automatic step(input logic v, input logic r, input string tag);
        valid_i = v;
        rst_i   = r;
        if (r) begin
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_datak = '0;
            for (int l = 0; l < LANES; l++) m_lfsr[l] = SEED;
        end else begin
            exp_valid = v;
            if (v) model_word();
        end
        @(posedge clk_i);
        #1;
        check({tag, ".valid"}, {63'd0, valid_o}, {63'd0, exp_valid});
        check({tag, ".data"},  data_o,           exp_data);
        check({tag, ".datak"}, {56'd0, datak_o}, {56'd0, exp_datak});
        check({tag, ".lfsr"},  lfsr_state_o,     model_lfsr_flat());
    endtask

    task automatic clear_word();
        data_i            = '0;
        datak_i           = '0;
        scramble_enable_i = '1;
    endtask

    task automatic put(input int lane, input int j, input logic [7:0] b,
                       input logic k);
        data_i[(lane*SYMS+j)*8 +: 8] = b;
        datak_i[lane*SYMS+j]         = k;
    endtask

    function automatic logic [7:0] rand_k_byte();
        logic [7:0] tbl [7];
        tbl = '{8'hBC, 8'h1C, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'h7C};
        return tbl[$urandom_range(0, 6)];
    endfunction

    initial begin
        for (int l = 0; l < LANES; l++) m_lfsr[l] = SEED;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_datak = '0;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        clear_word();
        @(posedge clk_i);
        #1;

        // Reset with garbage on the inputs.
        data_i  = {$urandom, $urandom};
        datak_i = 8'hA5;
        step(1'b1, 1'b1, "reset0");
        step(1'b0, 1'b0, "idle0");

        // Lane 0: K BC, D 00 | D 00, D 00  ->  BC FF | 17 C0
        clear_word();
        put(0, 0, 8'hBC, 1'b1);
        step(1'b1, 1'b0, "tp1.w0");
        check("tp1.sym0", {56'd0, sym_out(0, 0)}, 64'hBC);
        check("tp1.sym1", {56'd0, sym_out(0, 1)}, 64'hFF);
        check("tp1.k",    {62'd0, datak_o[1:0]},  64'h1);
        clear_word();
        step(1'b1, 1'b0, "tp1.w1");
        check("tp1.sym2", {56'd0, sym_out(0, 0)}, 64'h17);
        check("tp1.sym3", {56'd0, sym_out(0, 1)}, 64'hC0);

        // Lane 1: K BC, K 1C | D 00  ->  BC 1C | FF, state still seed.
        clear_word();
        put(1, 0, 8'hBC, 1'b1);
        put(1, 1, 8'h1C, 1'b1);
        step(1'b1, 1'b0, "tp2.w0");
        check("tp2.skp",  {56'd0, sym_out(1, 1)}, 64'h1C);
        check("tp2.lfsr", {48'd0, lfsr_out(1)},   64'hFFFF);
        clear_word();
        step(1'b1, 1'b0, "tp2.w1");
        check("tp2.d0", {56'd0, sym_out(1, 0)}, 64'hFF);

        // Lane 2 disabled: D 5A passes through, LFSR held; then COM re-enabled.
        clear_word();
        scramble_enable_i[2] = 1'b0;
        put(2, 0, 8'h5A, 1'b0);
        put(2, 1, 8'h5A, 1'b0);
        step(1'b1, 1'b0, "tp3.w0");
        check("tp3.pass0", {56'd0, sym_out(2, 0)}, 64'h5A);
        step(1'b1, 1'b0, "tp3.w1");
        check("tp3.pass1", {56'd0, sym_out(2, 1)}, 64'h5A);
        clear_word();
        put(2, 0, 8'hBC, 1'b1);
        step(1'b1, 1'b0, "tp3.w2");
        check("tp3.ff", {56'd0, sym_out(2, 1)}, 64'hFF);
        clear_word();
        step(1'b1, 1'b0, "tp3.w3");
        check("tp3.17", {56'd0, sym_out(2, 0)}, 64'h17);
        // COM reseeds a disabled lane too.
        clear_word();
        scramble_enable_i[2] = 1'b0;
        put(2, 1, 8'hBC, 1'b1);
        step(1'b1, 1'b0, "tp3.w4");
        check("tp3.dis_com", {48'd0, lfsr_out(2)}, 64'hFFFF);

        // Lane 3: K BC, D BC | D 00  ->  BC 43 | 17
        clear_word();
        put(3, 0, 8'hBC, 1'b1);
        put(3, 1, 8'hBC, 1'b0);
        step(1'b1, 1'b0, "tp4.w0");
        check("tp4.43", {56'd0, sym_out(3, 1)}, 64'h43);
        clear_word();
        step(1'b1, 1'b0, "tp4.w1");
        check("tp4.17", {56'd0, sym_out(3, 0)}, 64'h17);

        // Lane 0: COM, D00 | 3 idle cycles | D00 -> 17, no key gap.
        clear_word();
        put(0, 0, 8'hBC, 1'b1);
        step(1'b1, 1'b0, "tp5.w0");
        for (int c = 0; c < 3; c++) begin
            data_i  = {$urandom, $urandom};
            datak_i = 8'($urandom);
            step(1'b0, 1'b0, "tp5.idle");
            check("tp5.hold", {56'd0, sym_out(0, 1)}, 64'hFF);
        end
        clear_word();
        step(1'b1, 1'b0, "tp5.w1");
        check("tp5.resume", {56'd0, sym_out(0, 0)}, 64'h17);

        // Reset mid-stream with valid high and non-seed states.
        clear_word();
        step(1'b1, 1'b0, "tp6.adv");
        step(1'b1, 1'b1, "tp6.rst");
        check("tp6.lfsr", lfsr_state_o, {4{16'hFFFF}});
        clear_word();
        step(1'b1, 1'b0, "tp6.w0");
        for (int l = 0; l < LANES; l++)
            check("tp6.ff", {56'd0, sym_out(l, 0)}, 64'hFF);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NSYM; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    data_i[i*8 +: 8] = rand_k_byte();
                    datak_i[i]       = 1'b1;
                end else begin
                    data_i[i*8 +: 8] = ($urandom_range(0, 7) == 0) ? 8'hBC : 8'($urandom);
                    datak_i[i]       = 1'b0;
                end
            end
            for (int l = 0; l < LANES; l++)
                scramble_enable_i[l] = ($urandom_range(0, 5) != 0);
            step($urandom_range(0, 5) != 0, $urandom_range(0, 63) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
